// File: rtl/wb_pipe_reg_pkg.sv
// Shared types for the MEM->WB pipeline register: default widths, write-back
// control bundle and the write-back source select.
package wb_pipe_reg_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RADDR_W_DEF = 4;

  typedef struct packed {
    logic hlt;
    logic memtoreg;
    logic regwrite;
    logic pcs;
  } wb_ctrl_t;

  localparam int CTRL_W = $bits(wb_ctrl_t);

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC  = 2'd2
  } wb_sel_e;

  // PCS outranks memtoreg: a link write always takes the return address.
  function automatic wb_sel_e wb_sel(input wb_ctrl_t c);
    if (c.pcs)           return WB_SEL_PC;
    else if (c.memtoreg) return WB_SEL_MEM;
    else                 return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_pipe_reg_entry.sv
// One pipeline slot: payload register plus valid flag, with load, drop and
// synchronous clear. Payload only changes on load.
module wb_pipe_reg_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q;

  always_comb begin
    valid_d = valid_q;
    if (load_i)      valid_d = 1'b1;
    else if (drop_i) valid_d = 1'b0;
    if (clr_i)       valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst)         data_q <= '0;
    else if (load_i) data_q <= d_i;
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, flush, optional skid
// entry, sticky halt and a write-back data select driven from the main entry.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int SKID    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]  in_memdata,
  input  logic [DATA_W-1:0]  in_aluout,
  input  logic [DATA_W-1:0]  in_nxt_pc,
  input  logic               in_hlt,
  input  logic               in_memtoreg,
  input  logic               in_regwrite,
  input  logic               in_pcs,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0]  out_wdata,
  output logic               out_regwrite,
  output logic               out_hlt,
  output logic               halted,
  output logic [1:0]         occupancy
);

  localparam int PL_W = RADDR_W + 3*DATA_W + CTRL_W;

  logic [PL_W-1:0]   in_pl, main_d, main_pl;
  logic              main_valid, main_load, skid_valid_w;
  logic              accept, pop, halted_q, halted_d;
  wb_ctrl_t          main_ctrl;
  logic [DATA_W-1:0] main_npc, main_alu, main_mem;

  assign in_pl  = {in_dest, in_memdata, in_aluout, in_nxt_pc,
                   in_hlt, in_memtoreg, in_regwrite, in_pcs};
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready;

  wb_pipe_reg_entry #(.W(PL_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .load_i  (main_load),
    .drop_i  (pop),
    .d_i     (main_d),
    .valid_o (main_valid),
    .q_o     (main_pl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic            skid_valid, skid_load;
      logic [PL_W-1:0] skid_pl;

      // in_ready comes straight from the skid flag, so downstream stall never
      // reaches upstream combinationally; the skid absorbs the beat in flight.
      assign skid_load = accept & ((pop & skid_valid) | (~pop & main_valid));
      assign main_load = ~flush & ((pop & skid_valid) | (accept & (~main_valid | pop)));
      assign main_d    = (pop & skid_valid) ? skid_pl : in_pl;
      assign in_ready  = ~skid_valid & ~halted_q;
      assign skid_valid_w = skid_valid;

      wb_pipe_reg_entry #(.W(PL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .load_i  (skid_load),
        .drop_i  (pop),
        .d_i     (in_pl),
        .valid_o (skid_valid),
        .q_o     (skid_pl)
      );
    end else begin : g_noskid
      assign main_load    = accept;
      assign main_d       = in_pl;
      assign in_ready     = (~main_valid | out_ready) & ~halted_q;
      assign skid_valid_w = 1'b0;
    end
  endgenerate

  assign main_ctrl = main_pl[CTRL_W-1:0];
  assign main_npc  = main_pl[CTRL_W +: DATA_W];
  assign main_alu  = main_pl[CTRL_W+DATA_W +: DATA_W];
  assign main_mem  = main_pl[CTRL_W+2*DATA_W +: DATA_W];
  assign out_dest  = main_pl[CTRL_W+3*DATA_W +: RADDR_W];

  always_comb begin
    out_wdata = main_alu;
    unique case (wb_sel(main_ctrl))
      WB_SEL_PC:  out_wdata = main_npc;
      WB_SEL_MEM: out_wdata = main_mem;
      default:    out_wdata = main_alu;
    endcase
  end

  assign out_valid    = main_valid & ~halted_q;
  assign out_regwrite = main_ctrl.regwrite & out_valid;
  assign out_hlt      = main_ctrl.hlt & out_valid;

  // A halt popped in a flush cycle still retires.
  assign halted_d = halted_q | (pop & out_hlt);

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted    = halted_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid_w};

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: SKID=1 and SKID=0 instances driven in lockstep and
// compared each cycle against a queue-based model of the handshake.
module tb_wb_pipe_reg;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] mem;
    logic [15:0] alu;
    logic [15:0] npc;
    logic        hlt;
    logic        m2r;
    logic        rw;
    logic        pcs;
  } beat_t;

  logic clk, rst, flush, in_valid, out_ready;
  logic [3:0]  in_dest;
  logic [15:0] in_memdata, in_aluout, in_nxt_pc;
  logic in_hlt, in_memtoreg, in_regwrite, in_pcs;

  logic        ir [2];
  logic        ov [2];
  logic [3:0]  od [2];
  logic [15:0] wd [2];
  logic        orw[2];
  logic        oh [2];
  logic        hl [2];
  logic [1:0]  occ[2];

  int tests = 0;
  int fails = 0;

  beat_t q1[$];
  beat_t q0[$];
  bit    h1, h0;

  wb_pipe_reg #(.DATA_W(16), .RADDR_W(4), .SKID(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_dest(in_dest), .in_memdata(in_memdata), .in_aluout(in_aluout),
    .in_nxt_pc(in_nxt_pc), .in_hlt(in_hlt), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_pcs(in_pcs), .out_valid(ov[1]),
    .out_ready(out_ready), .out_dest(od[1]), .out_wdata(wd[1]),
    .out_regwrite(orw[1]), .out_hlt(oh[1]), .halted(hl[1]), .occupancy(occ[1]));

  wb_pipe_reg #(.DATA_W(16), .RADDR_W(4), .SKID(0)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_dest(in_dest), .in_memdata(in_memdata), .in_aluout(in_aluout),
    .in_nxt_pc(in_nxt_pc), .in_hlt(in_hlt), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_pcs(in_pcs), .out_valid(ov[0]),
    .out_ready(out_ready), .out_dest(od[0]), .out_wdata(wd[0]),
    .out_regwrite(orw[0]), .out_hlt(oh[0]), .halted(hl[0]), .occupancy(occ[0]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [15:0] alu, input logic [15:0] mem,
                               input logic [15:0] npc, input logic m2r,
                               input logic rw, input logic pcs, input logic hlt);
    beat_t b;
    b.dest = 4'($urandom_range(0, 15));
    b.alu = alu; b.mem = mem; b.npc = npc;
    b.m2r = m2r; b.rw = rw; b.pcs = pcs; b.hlt = hlt;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
  endfunction

  function automatic logic [15:0] exp_wdata(input beat_t b);
    if (b.pcs)      return b.npc;
    else if (b.m2r) return b.mem;
    else            return b.alu;
  endfunction

  // Readiness from the model's point of view: SKID=1 accepts while fewer than
  // two beats are held; SKID=0 accepts when empty or the held beat leaves now.
  function automatic logic mrdy(input int m);
    if (m == 1) return (q1.size() < 2) && !h1;
    else        return ((q0.size() == 0) || out_ready) && !h0;
  endfunction

  task automatic check_dut(input int m);
    int    sz;
    bit    hb;
    beat_t hd;
    logic  v;
    hd = '0;
    if (m == 1) begin sz = q1.size(); hb = h1; if (sz > 0) hd = q1[0]; end
    else        begin sz = q0.size(); hb = h0; if (sz > 0) hd = q0[0]; end
    v = (sz > 0) && !hb;
    chk($sformatf("s%0d_out_valid", m), ov[m], v);
    chk($sformatf("s%0d_in_ready", m), ir[m], mrdy(m));
    chk($sformatf("s%0d_occupancy", m), occ[m], sz);
    chk($sformatf("s%0d_halted", m), hl[m], hb);
    chk($sformatf("s%0d_regwrite", m), orw[m], v & hd.rw);
    chk($sformatf("s%0d_out_hlt", m), oh[m], v & hd.hlt);
    if (v) begin
      chk($sformatf("s%0d_wdata", m), wd[m], exp_wdata(hd));
      chk($sformatf("s%0d_dest", m), od[m], hd.dest);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.dest = in_dest; b.mem = in_memdata; b.alu = in_aluout; b.npc = in_nxt_pc;
    b.hlt = in_hlt; b.m2r = in_memtoreg; b.rw = in_regwrite; b.pcs = in_pcs;
    return b;
  endfunction

  task automatic model_edge();
    logic r1, r0;
    r1 = mrdy(1);
    r0 = mrdy(0);
    if (q1.size() > 0 && !h1 && out_ready) begin
      if (q1[0].hlt) h1 = 1'b1;
      void'(q1.pop_front());
    end
    if (q0.size() > 0 && !h0 && out_ready) begin
      if (q0[0].hlt) h0 = 1'b1;
      void'(q0.pop_front());
    end
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (in_valid && r1) q1.push_back(cur_beat());
      if (in_valid && r0) q0.push_back(cur_beat());
    end
  endtask

  task automatic cycle(input logic vld, input logic rdy, input logic fl, input beat_t b);
    in_valid = vld; out_ready = rdy; flush = fl;
    in_dest = b.dest; in_memdata = b.mem; in_aluout = b.alu; in_nxt_pc = b.npc;
    in_hlt = b.hlt; in_memtoreg = b.m2r; in_regwrite = b.rw; in_pcs = b.pcs;
    #1;
    check_dut(1);
    check_dut(0);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete(); q0.delete(); h1 = 1'b0; h0 = 1'b0;
  endtask

  beat_t idle_b, a_b, b_b;

  initial begin
    idle_b = '0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_dest = '0; in_memdata = '0; in_aluout = '0; in_nxt_pc = '0;
    in_hlt = 1'b0; in_memtoreg = 1'b0; in_regwrite = 1'b0; in_pcs = 1'b0;

    // Reset and idle
    do_reset();
    chk("rst_wdata", wd[1], 16'h0);
    chk("rst_occ", occ[1], 2'd0);
    chk("rst_in_ready", ir[1], 1'b1);
    cycle(1'b0, 1'b0, 1'b0, idle_b);

    // Streaming with out_ready held high
    cycle(1'b1, 1'b1, 1'b0, mk(16'h0011, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    chk("stream_first", wd[1], 16'h0011);
    cycle(1'b1, 1'b1, 1'b0, mk(16'h0022, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    cycle(1'b1, 1'b1, 1'b0, mk(16'h0033, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    chk("stream_last", wd[0], 16'h0033);
    cycle(1'b0, 1'b1, 1'b0, idle_b);
    cycle(1'b0, 1'b1, 1'b0, idle_b);

    // Back-pressure: two beats held in SKID=1, second refused by SKID=0
    a_b = mk(16'hAAAA, 16'h1234, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    b_b = mk(16'h5678, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, a_b);
    cycle(1'b1, 1'b0, 1'b0, b_b);
    chk("bp_occ_full", occ[1], 2'd2);
    chk("bp_ready_low", ir[1], 1'b0);
    cycle(1'b0, 1'b0, 1'b0, idle_b);
    cycle(1'b0, 1'b1, 1'b0, idle_b);
    chk("bp_second", wd[1], 16'h5678);
    cycle(1'b0, 1'b1, 1'b0, idle_b);
    cycle(1'b0, 1'b1, 1'b0, idle_b);

    // Flush at full occupancy with an incoming beat
    cycle(1'b1, 1'b0, 1'b0, a_b);
    cycle(1'b1, 1'b0, 1'b0, b_b);
    cycle(1'b1, 1'b0, 1'b1, mk(16'hBEEF, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    chk("flush_occ", occ[1], 2'd0);
    chk("flush_regwrite", orw[1], 1'b0);
    cycle(1'b0, 1'b1, 1'b0, idle_b);

    // PCS select beats ALU result
    cycle(1'b1, 1'b1, 1'b0, mk(16'hFFFF, 16'h0, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b0));
    chk("pcs_wdata", wd[1], 16'h0042);
    cycle(1'b0, 1'b1, 1'b0, idle_b);

    // Random traffic with back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), rnd_beat());
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, idle_b);

    // Halt retires, then everything stays blocked until reset
    cycle(1'b1, 1'b1, 1'b0, mk(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    cycle(1'b0, 1'b1, 1'b0, idle_b);
    chk("halt_sticky", hl[1], 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, rnd_beat());
    chk("halt_in_ready", ir[0], 1'b0);
    do_reset();
    chk("halt_cleared", hl[1], 1'b0);
    cycle(1'b1, 1'b1, 1'b0, rnd_beat());
    cycle(1'b0, 1'b1, 1'b0, idle_b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
Parametrised MEM->WB pipeline register: the next generation of the fixed 16-bit, always-enabled stage register.
- Adds a valid/ready handshake, back-pressure, flush, an optional one-entry skid buffer, a sticky halt and a registered-output write-back select.
- Sits between the memory stage and register-file write port; downstream stall propagates upstream without a combinational ready path when SKID=1.

Parameters:
DATA_W, 16, width of mem data, ALU result, next-PC and write-back data
RADDR_W, 4, destination register index width
SKID, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry, in_ready = ~main_valid | out_ready

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  drop all held and incoming beats this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  block can accept a beat
in_dest  in  RADDR_W  destination register
in_memdata  in  DATA_W  data-memory read data
in_aluout  in  DATA_W  ALU result
in_nxt_pc  in  DATA_W  PC+2 for PCS
in_hlt, in_memtoreg, in_regwrite, in_pcs  in  1 each  control bits
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_dest  out  RADDR_W  held destination
out_wdata  out  DATA_W  pcs ? nxt_pc : memtoreg ? memdata : aluout
out_regwrite  out  1  held regwrite AND out_valid
out_hlt  out  1  held hlt AND out_valid
halted  out  1  sticky: halt beat retired
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst=1 at edge): main_valid=skid_valid=0, halted=0, all payload regs 0. After reset: out_valid=0, out_regwrite=0, out_hlt=0, out_wdata=0, occupancy=0, in_ready=1.
- Accept = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- Latency: accepted beat appears on out_* the next cycle when main empty or popping.
- SKID=1 transitions per edge:
  - pop & skid_valid: main<=skid; skid<=accepted beat if accept, else skid empties.
  - pop & ~skid_valid: main<=accepted beat, or empties.
  - ~pop & main empty: main<=accepted beat.
  - ~pop & main full & accept: skid<=beat.
  - in_ready = ~skid_valid, purely registered.
- SKID=0: in_ready = ~main_valid | out_ready; no skid register is generated.
- flush (priority over all except rst): main_valid, skid_valid <= 0; no accept that cycle; a pop in the flush cycle still counts as retired for halted.
- Invalid entries never drive side effects: out_regwrite and out_hlt gated by out_valid. Payload of invalid entries is don't-care, but must not toggle when no load occurs.
- halted <= 1 on pop with out_hlt=1; cleared only by rst. While halted: in_ready=0, out_valid forced 0.
- out_wdata mux is combinational from main regs only, with no input-to-output path.
- occupancy = main_valid + skid_valid.
- Simultaneous accept+pop at occupancy 2 is impossible: in_ready=0.

Decomposition:
- Shared package: DATA_W/RADDR_W defaults, wb control struct {hlt, memtoreg, regwrite, pcs}, wb_sel encoding.
- One natural sub-module: wb_entry_reg (payload+valid register with load enable and synchronous clear), instantiated for main and, when SKID=1, for skid.

Test Plan:
- Reset then idle: rst=1 two cycles -> out_valid=0, in_ready=1, occupancy=0, halted=0.
- Streaming, out_ready=1: beats aluout=0x0011,0x0022,0x0033 with regwrite=1 -> identical out_wdata sequence one cycle later, no bubbles.
- Back-pressure (SKID=1): out_ready=0, send A=0x1234 (memtoreg=1, memdata) and B=0x5678 -> occupancy=2, in_ready=0; release out_ready -> A then B in order, no loss or duplication.
- Flush at occupancy 2: assert flush with in_valid=1 -> next cycle occupancy=0, out_regwrite=0, incoming beat dropped.
- PCS select: pcs=1, nxt_pc=0x0042, aluout=0xFFFF -> out_wdata=0x0042.
- Halt: beat hlt=1 retires -> halted=1, in_ready=0 thereafter until rst; SKID=0 rerun of the streaming and back-pressure cases passes.
